// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port VRAM arbiter; display fetch has absolute priority,
// queued draw writes and readbacks share the remaining cycles round-robin.
module vram_arbiter #(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 12,
  parameter int WQ_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_valid,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);
  localparam int PW = $clog2(WQ_DEPTH);
  localparam int CW = PW + 1;
  logic [ADDR_W-1:0] qa_q [WQ_DEPTH];
  logic [DATA_W-1:0] qd_q [WQ_DEPTH];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic last_rd_q, last_rd_d, disp_pend_q, rd_pend_q;
  logic [DATA_W-1:0] disp_hold_q, rd_hold_q;
  logic haz, full, push, wr_el, rd_el, g_disp, g_wr, g_rd;
  // A read is blocked while any occupied queue slot targets the same address.
  always_comb begin
    haz = 1'b0;
    for (int i = 0; i < WQ_DEPTH; i++)
      haz = haz | ((CW'(PW'(PW'(i) - rp_q)) < cnt_q) && (qa_q[i] == rd_addr));
  end
  always_comb begin
    full      = cnt_q == CW'(WQ_DEPTH);
    wr_el     = cnt_q != '0;
    rd_el     = rd_valid & ~haz;
    g_disp    = rst & disp_req;
    g_wr      = rst & ~disp_req & wr_el & (~rd_el | last_rd_q);
    g_rd      = rst & ~disp_req & rd_el & (~wr_el | ~last_rd_q);
    wr_ready  = rst & ~full;
    push      = wr_valid & wr_ready;
    rd_ready  = g_rd;
    ram_en    = g_disp | g_wr | g_rd;
    ram_we    = g_wr;
    ram_addr  = g_disp ? disp_addr : (g_wr ? qa_q[rp_q] : rd_addr);
    ram_wdata = qd_q[rp_q];
    busy      = wr_el;
    wp_d      = push ? wp_q + 1'b1 : wp_q;
    rp_d      = g_wr ? rp_q + 1'b1 : rp_q;
    cnt_d     = cnt_q + CW'(push) - CW'(g_wr);
    last_rd_d = g_rd ? 1'b1 : (g_wr ? 1'b0 : last_rd_q);
    disp_data     = disp_pend_q ? ram_rdata : disp_hold_q;
    disp_valid    = disp_pend_q;
    rd_data       = rd_pend_q ? ram_rdata : rd_hold_q;
    rd_data_valid = rd_pend_q;
  end
  always_ff @(posedge clk) begin
    if (push) begin
      qa_q[wp_q] <= wr_addr;
      qd_q[wp_q] <= wr_data;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q        <= '0;
      rp_q        <= '0;
      cnt_q       <= '0;
      last_rd_q   <= 1'b1;
      disp_pend_q <= 1'b0;
      rd_pend_q   <= 1'b0;
      disp_hold_q <= '0;
      rd_hold_q   <= '0;
    end else begin
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      cnt_q       <= cnt_d;
      last_rd_q   <= last_rd_d;
      disp_pend_q <= g_disp;
      rd_pend_q   <= g_rd;
      disp_hold_q <= disp_data;
      rd_hold_q   <= rd_data;
    end
  end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: random and directed traffic checked cycle by cycle against
// a queue-based reference model of the arbitration rules and a shadow VRAM.
module tb_vram_arbiter;
  logic        clk = 1'b0, rst = 1'b0;
  logic        disp_req = 0, wr_valid = 0, rd_valid = 0;
  logic [14:0] disp_addr = 0, wr_addr = 0, rd_addr = 0;
  logic [11:0] wr_data = 0;
  logic [11:0] disp_data, rd_data, ram_wdata, ram_rdata;
  logic        disp_valid, wr_ready, rd_ready, rd_data_valid, ram_en, ram_we, busy;
  logic [14:0] ram_addr;
  logic [11:0] vmem [0:32767];
  logic [11:0] smem [0:32767];
  typedef struct { logic [14:0] a; logic [11:0] d; } ent_t;
  ent_t wq[$];
  bit last_rd;
  logic ev_d, ev_r;
  logic [11:0] ed_d, ed_r;
  int n_chk = 0, n_fail = 0;

  vram_arbiter dut (
    .clk(clk), .rst(rst),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_data_valid(rd_data_valid), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) vmem[ram_addr] <= ram_wdata;
      ram_rdata <= vmem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit dr, input logic [14:0] da, input bit wv, input logic [14:0] wa,
                      input logic [11:0] wd, input bit rv, input logic [14:0] ra);
    bit full, haz, wel, rel;
    int g;
    ent_t h;
    @(negedge clk);
    disp_req = dr; disp_addr = da; wr_valid = wv; wr_addr = wa; wr_data = wd;
    rd_valid = rv; rd_addr = ra;
    #1;
    full = wq.size() == 4;
    haz = 0;
    foreach (wq[i]) if (wq[i].a == ra) haz = 1;
    wel = wq.size() != 0;
    rel = rv && !haz;
    g = dr ? 1 : (wel && rel) ? (last_rd ? 2 : 3) : wel ? 2 : rel ? 3 : 0;
    chk("disp_valid", 32'(disp_valid), 32'(ev_d));
    chk("disp_data", 32'(disp_data), 32'(ed_d));
    chk("rd_data_valid", 32'(rd_data_valid), 32'(ev_r));
    chk("rd_data", 32'(rd_data), 32'(ed_r));
    chk("wr_ready", 32'(wr_ready), 32'(!full));
    chk("busy", 32'(busy), 32'(wel));
    chk("ram_en", 32'(ram_en), 32'(g != 0));
    chk("ram_we", 32'(ram_we), 32'(g == 2));
    chk("rd_ready", 32'(rd_ready), 32'(g == 3));
    if (g == 1) chk("disp_addr", 32'(ram_addr), 32'(da));
    if (g == 3) chk("rd_addr", 32'(ram_addr), 32'(ra));
    if (g == 2) begin
      h = wq.pop_front();
      chk("wr_addr", 32'(ram_addr), 32'(h.a));
      chk("wr_data", 32'(ram_wdata), 32'(h.d));
      smem[h.a] = h.d;
      last_rd = 0;
    end
    if (g == 3) last_rd = 1;
    ev_d = g == 1;
    if (g == 1) ed_d = smem[da];
    ev_r = g == 3;
    if (g == 3) ed_r = smem[ra];
    if (wv && !full) wq.push_back('{wa, wd});
  endtask

  task automatic do_reset(input int ncyc);
    @(negedge clk);
    rst = 0; disp_req = 0; wr_valid = 1; rd_valid = 1;
    wq.delete(); last_rd = 1; ev_d = 0; ev_r = 0; ed_d = 0; ed_r = 0;
    for (int c = 0; c < ncyc; c++) begin
      #1;
      chk("rst_wr_ready", 32'(wr_ready), 0);
      chk("rst_rd_ready", 32'(rd_ready), 0);
      chk("rst_disp_valid", 32'(disp_valid), 0);
      chk("rst_rd_data_valid", 32'(rd_data_valid), 0);
      chk("rst_ram_en", 32'(ram_en), 0);
      chk("rst_ram_we", 32'(ram_we), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_disp_data", 32'(disp_data), 0);
      chk("rst_rd_data", 32'(rd_data), 0);
      @(negedge clk);
    end
    rst = 1; wr_valid = 0; rd_valid = 0;
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) begin
      vmem[i] = 12'(i * 37 + 5);
      smem[i] = 12'(i * 37 + 5);
    end
    ram_rdata = 0;
    do_reset(2);
    // Contended writes and reads alternate, write first after reset.
    for (int i = 0; i < 10; i++)
      step(0, 0, 1, 15'(16'h100 + i), 12'($urandom), 1, 15'h200);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0);
    // Display blocks everything while the queue fills, then the queue drains.
    for (int i = 0; i < 6; i++)
      step(1, 15'(i), 1, 15'(16'h40 + i), 12'($urandom), 1, 15'h300);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0, 0);
    // Read-after-write hazard on 0x0123.
    step(1, 15'h10, 1, 15'h123, 12'hABC, 0, 0);
    step(0, 0, 0, 0, 0, 1, 15'h123);
    step(0, 0, 0, 0, 0, 1, 15'h123);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("raw_rd_data", 32'(rd_data), 32'h0ABC);
    // Randomized traffic on a small address window so hazards occur.
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) == 0, 15'($urandom_range(0, 7)),
           $urandom_range(0, 9) < 6, 15'($urandom_range(0, 7)), 12'($urandom),
           $urandom_range(0, 9) < 6, 15'($urandom_range(0, 7)));
    // Reset with three queued writes and a read in flight.
    do_reset(1);
    for (int i = 0; i < 4; i++)
      step(1, 15'(i), 1, 15'(16'h500 + i), 12'($urandom), 0, 0);
    step(0, 0, 0, 0, 0, 1, 15'h600);
    step(0, 0, 0, 0, 0, 1, 15'h601);
    chk("pre_rst_rd_ready", 32'(rd_ready), 1);
    do_reset(1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0);
    chk("post_rst_vmem", 32'(vmem[15'h501]), 32'(smem[15'h501]));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
